// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle for serial_pattern_tx.
// The transmitter uses the slave view; the stimulus source uses the master view.
interface serial_pattern_tx_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [MAX_LEN-1:0] in_data;
  logic [LEN_W-1:0]   in_len;
  logic               x;
  logic               x_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   hit_count;

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, x, x_valid, busy, done, hit_count
  );

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, x, x_valid, busy, done, hit_count
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter: shifts a latched pattern out MSB-first, adds an idle
// gap, and keeps an overlapping "101" reference count for the frame being sent.
module serial_pattern_tx #(
  parameter int MAX_LEN = 16,
  parameter int GAP     = 2,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  serial_pattern_tx_if.slave bus
);
  localparam int LEN_W    = $clog2(MAX_LEN) + 1;
  localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int GAP_INIT = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               x_q, x_d;
  logic               xv_q, xv_d;
  logic               done_q, done_d;
  logic [1:0]         hist_q, hist_d;
  logic [CNT_W-1:0]   hit_q, hit_d;

  logic [LEN_W-1:0]   l_eff;
  logic [IDX_W-1:0]   first_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Oversized lengths are clamped so the first bit sent is the word's MSB.
  assign l_eff     = (bus.in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.in_len;
  assign first_idx = IDX_W'(l_eff - 1'b1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    done_d  = 1'b0;
    hist_d  = hist_q;
    hit_d   = hit_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d = bus.in_data;
          hist_d = '0;
          hit_d  = '0;
          if (l_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SHIFT;
            idx_d   = first_idx;
            x_d     = bus.in_data[first_idx];
            xv_d    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        // x_q is the bit on the line this cycle; the history holds the two before it.
        hist_d = {hist_q[0], x_q};
        if (hist_q == 2'b10 && x_q) hit_d = sat_inc(hit_q);
        if (idx_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_INIT);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q - 1'b1;
          x_d   = data_q[idx_q - 1'b1];
          xv_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    idx_q  <= idx_d;
    gap_q  <= gap_d;
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
      hist_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
      hist_q  <= hist_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hit_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomised and directed bench for serial_pattern_tx, compared cycle by cycle
// against a frame-level reference model.
module tb_serial_pattern_tx;
  localparam int MAX_LEN = 16;
  localparam int GAP     = 2;
  localparam int CNT_W   = 8;
  localparam int NC      = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus_if ();

  serial_pattern_tx #(.MAX_LEN(MAX_LEN), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]      o_x, o_xv, o_busy, o_rdy, o_done;
  logic [CNT_W-1:0] o_hit [0:NC];
  logic [CNT_W-1:0] o_hit_end;
  logic [31:0]      e_x, e_xv, e_busy, e_rdy, e_done;
  int               e_hit;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level expectations; bit c-1 of each vector describes cycle c after the accept edge.
  task automatic model_frame(input logic [15:0] d, input int len);
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    e_x = '0; e_xv = '0; e_busy = '0; e_rdy = '0; e_done = '0;
    for (int c = 1; c <= NC; c++) begin
      if (l > 0) begin
        if (c <= l) begin
          e_xv[c-1] = 1'b1;
          e_x[c-1]  = d[l-c];
        end
        if (c <= l + GAP) e_busy[c-1] = 1'b1;
        if (c == l + GAP + 1) e_done[c-1] = 1'b1;
      end else if (c == 1) begin
        e_done[c-1] = 1'b1;
      end
      e_rdy[c-1] = ~e_busy[c-1];
    end
    e_hit = 0;
    for (int i = l - 1; i >= 2; i--)
      if (d[i] && !d[i-1] && d[i-2]) e_hit++;
    if (e_hit > (1 << CNT_W) - 1) e_hit = (1 << CNT_W) - 1;
  endtask

  // Offers one word while idle, then records NC cycles of outputs.
  task automatic capture_frame(input logic [15:0] d, input int len);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_len   = len[4:0];
    step();
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 16'($urandom);
    bus_if.in_len   = 5'($urandom);
    o_x = '0; o_xv = '0; o_busy = '0; o_rdy = '0; o_done = '0;
    for (int c = 1; c <= NC; c++) begin
      o_x[c-1]    = bus_if.x;
      o_xv[c-1]   = bus_if.x_valid;
      o_busy[c-1] = bus_if.busy;
      o_rdy[c-1]  = bus_if.in_ready;
      o_done[c-1] = bus_if.done;
      o_hit[c]    = bus_if.hit_count;
      step();
    end
    o_hit_end = bus_if.hit_count;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 16'h0005;
    bus_if.in_len   = 5'd3;
    repeat (3) step();
    reset = 1'b0;
    bus_if.in_valid = 1'b0;
    n_checks++;
    if ({bus_if.in_ready, bus_if.busy, bus_if.x, bus_if.x_valid, bus_if.done} !== 5'b10000)
      $display("FAIL reset_ctrl: got rdy/busy/x/xv/done=%b want 10000",
               {bus_if.in_ready, bus_if.busy, bus_if.x, bus_if.x_valid, bus_if.done});
    else n_pass++;
    n_checks++;
    if (bus_if.hit_count !== '0) $display("FAIL reset_hit: got %0d want 0", bus_if.hit_count);
    else n_pass++;
  endtask

  task automatic test_basic();
    model_frame(16'h0005, 3);
    capture_frame(16'h0005, 3);
    n_checks++; if (o_x !== e_x)       $display("FAIL basic_x: got %h want %h", o_x, e_x);             else n_pass++;
    n_checks++; if (o_xv !== e_xv)     $display("FAIL basic_xv: got %h want %h", o_xv, e_xv);          else n_pass++;
    n_checks++; if (o_rdy !== e_rdy)   $display("FAIL basic_rdy: got %h want %h", o_rdy, e_rdy);       else n_pass++;
    n_checks++; if (o_done !== 32'h20) $display("FAIL basic_done: got %h want %h", o_done, 32'h20);    else n_pass++;
    n_checks++; if (o_hit_end !== 8'd1) $display("FAIL basic_hit: got %0d want 1", o_hit_end);         else n_pass++;
  endtask

  task automatic test_overlap();
    model_frame(16'h0015, 5);
    capture_frame(16'h0015, 5);
    n_checks++; if (o_x !== e_x)         $display("FAIL overlap_x: got %h want %h", o_x, e_x);         else n_pass++;
    n_checks++; if (o_xv !== e_xv)       $display("FAIL overlap_xv: got %h want %h", o_xv, e_xv);      else n_pass++;
    n_checks++; if (o_hit_end !== 8'd2)  $display("FAIL overlap_hit: got %0d want 2", o_hit_end);      else n_pass++;
  endtask

  task automatic test_full_width();
    model_frame(16'hFFFF, 16);
    capture_frame(16'hFFFF, 16);
    n_checks++; if (o_x !== e_x)         $display("FAIL full_x: got %h want %h", o_x, e_x);            else n_pass++;
    n_checks++; if (o_xv !== 32'hFFFF)   $display("FAIL full_xv: got %h want %h", o_xv, 32'hFFFF);     else n_pass++;
    n_checks++; if ($countones(o_busy) != 18) $display("FAIL full_busy: got %0d cycles want 18", $countones(o_busy)); else n_pass++;
    n_checks++; if (o_done !== e_done)   $display("FAIL full_done: got %h want %h", o_done, e_done);   else n_pass++;
    n_checks++; if (o_hit_end !== 8'd0)  $display("FAIL full_hit: got %0d want 0", o_hit_end);         else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_x, a_xv, a_busy, a_rdy, a_done;
    logic        drop;
    model_frame(16'h0005, 3);
    a_x = e_x; a_xv = e_xv; a_busy = e_busy; a_rdy = e_rdy; a_done = e_done;
    model_frame(16'h0001, 2);
    e_x    = a_x | (e_x << 6);
    e_xv   = a_xv | (e_xv << 6);
    e_busy = a_busy | (e_busy << 6);
    e_done = a_done | (e_done << 6);
    e_rdy  = a_rdy & ((e_rdy << 6) | 32'h3F);

    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 16'h0005;
    bus_if.in_len   = 5'd3;
    step();
    bus_if.in_data  = 16'h0001;
    bus_if.in_len   = 5'd2;
    o_x = '0; o_xv = '0; o_busy = '0; o_rdy = '0; o_done = '0;
    for (int c = 1; c <= NC; c++) begin
      o_x[c-1]    = bus_if.x;
      o_xv[c-1]   = bus_if.x_valid;
      o_busy[c-1] = bus_if.busy;
      o_rdy[c-1]  = bus_if.in_ready;
      o_done[c-1] = bus_if.done;
      o_hit[c]    = bus_if.hit_count;
      drop = bus_if.in_ready && bus_if.in_valid;
      step();
      if (drop) bus_if.in_valid = 1'b0;
    end
    o_hit_end = bus_if.hit_count;
    n_checks++; if (o_x !== e_x)       $display("FAIL b2b_x: got %h want %h", o_x, e_x);               else n_pass++;
    n_checks++; if (o_xv !== e_xv)     $display("FAIL b2b_xv: got %h want %h", o_xv, e_xv);            else n_pass++;
    n_checks++; if (o_busy !== e_busy) $display("FAIL b2b_busy: got %h want %h", o_busy, e_busy);      else n_pass++;
    n_checks++; if (o_rdy !== e_rdy)   $display("FAIL b2b_rdy: got %h want %h", o_rdy, e_rdy);         else n_pass++;
    n_checks++; if (o_done !== e_done) $display("FAIL b2b_done: got %h want %h", o_done, e_done);      else n_pass++;
    n_checks++; if (o_hit[6] !== 8'd1) $display("FAIL b2b_hit_a: got %0d want 1", o_hit[6]);           else n_pass++;
    n_checks++; if (o_hit_end !== 8'd0) $display("FAIL b2b_hit_b: got %0d want 0", o_hit_end);         else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 16'h00B5;
    bus_if.in_len   = 5'd8;
    step();
    bus_if.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus_if.x_valid !== 1'b1) $display("FAIL midrst_pre: got xv=%b want 1", bus_if.x_valid);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({bus_if.x_valid, bus_if.busy, bus_if.in_ready, bus_if.done} !== 4'b0010)
      $display("FAIL midrst_ctrl: got xv/busy/rdy/done=%b want 0010",
               {bus_if.x_valid, bus_if.busy, bus_if.in_ready, bus_if.done});
    else n_pass++;
    n_checks++;
    if (bus_if.hit_count !== '0) $display("FAIL midrst_hit: got %0d want 0", bus_if.hit_count);
    else n_pass++;
    model_frame(16'h0005, 3);
    capture_frame(16'h0005, 3);
    n_checks++; if (o_x !== e_x)       $display("FAIL midrst_x: got %h want %h", o_x, e_x);            else n_pass++;
    n_checks++; if (o_rdy !== e_rdy)   $display("FAIL midrst_rdy: got %h want %h", o_rdy, e_rdy);      else n_pass++;
    n_checks++; if (o_done !== e_done) $display("FAIL midrst_done: got %h want %h", o_done, e_done);   else n_pass++;
    n_checks++; if (o_hit_end !== 8'd1) $display("FAIL midrst_hit_end: got %0d want 1", o_hit_end);    else n_pass++;
  endtask

  task automatic test_len_edges();
    logic [15:0] d;
    d = 16'($urandom);
    model_frame(d, 0);
    capture_frame(d, 0);
    n_checks++; if (o_xv !== '0)       $display("FAIL len0_xv: got %h want 0", o_xv);                  else n_pass++;
    n_checks++; if (o_done !== 32'h1)  $display("FAIL len0_done: got %h want %h", o_done, 32'h1);      else n_pass++;
    n_checks++; if (o_busy !== e_busy) $display("FAIL len0_busy: got %h want %h", o_busy, e_busy);     else n_pass++;
    d = 16'($urandom) | 16'h8000;
    model_frame(d, 20);
    capture_frame(d, 20);
    n_checks++; if (o_x[0] !== 1'b1)   $display("FAIL len20_first: got %b want 1", o_x[0]);            else n_pass++;
    n_checks++; if (o_x !== e_x)       $display("FAIL len20_x: got %h want %h", o_x, e_x);             else n_pass++;
    n_checks++; if ($countones(o_xv) != 16) $display("FAIL len20_count: got %0d want 16", $countones(o_xv)); else n_pass++;
    n_checks++; if (o_hit_end !== CNT_W'(e_hit)) $display("FAIL len20_hit: got %0d want %0d", o_hit_end, e_hit); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] d;
    int len;
    for (int k = 0; k < 30; k++) begin
      d   = 16'($urandom);
      len = $urandom_range(0, 20);
      repeat ($urandom_range(0, 2)) step();
      model_frame(d, len);
      capture_frame(d, len);
      n_checks++; if (o_x !== e_x)       $display("FAIL rnd_x[%0d]: d=%h len=%0d got %h want %h", k, d, len, o_x, e_x);       else n_pass++;
      n_checks++; if (o_xv !== e_xv)     $display("FAIL rnd_xv[%0d]: d=%h len=%0d got %h want %h", k, d, len, o_xv, e_xv);    else n_pass++;
      n_checks++; if (o_busy !== e_busy) $display("FAIL rnd_busy[%0d]: got %h want %h", k, o_busy, e_busy);                   else n_pass++;
      n_checks++; if (o_rdy !== e_rdy)   $display("FAIL rnd_rdy[%0d]: got %h want %h", k, o_rdy, e_rdy);                      else n_pass++;
      n_checks++; if (o_done !== e_done) $display("FAIL rnd_done[%0d]: got %h want %h", k, o_done, e_done);                   else n_pass++;
      n_checks++; if (o_hit_end !== CNT_W'(e_hit)) $display("FAIL rnd_hit[%0d]: d=%h len=%0d got %0d want %0d", k, d, len, o_hit_end, e_hit); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_len   = '0;
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_full_width();
    test_back_to_back();
    test_reset_mid_shift();
    test_len_edges();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter: the sending side of the single-bit `x` stream consumed by the team's sequence-detector FSMs.
- Accepts a parallel pattern word and its length over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, then inserts a fixed idle gap.
- Keeps a reference count of overlapping "101" occurrences in each transmitted frame, for scoreboarding the detector.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits (width of in_data).
- GAP, 2: idle cycles inserted after each frame (0 allowed).
- CNT_W, 8: width of hit_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pattern word offered.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  MAX_LEN  pattern; bits [in_len-1:0] are used, bit in_len-1 is sent first.
- in_len  input  $clog2(MAX_LEN)+1  number of bits to send.
- x  output  1  serial data bit, registered.
- x_valid  output  1  x carries a pattern bit this cycle, registered.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse on the first IDLE cycle after a frame completes.
- hit_count  output  CNT_W  overlapping "101" count for the current or last frame.

Behaviour:
- Reset (synchronous, active-high, highest priority, valid in any state including mid-frame):
  - state=IDLE, x=0, x_valid=0, busy=0, done=0, hit_count=0, bit history cleared.
  - in_ready=1 in the first cycle after reset.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, x=0, x_valid=0.
  - Accept when in_valid && in_ready at a clock edge.
  - On accept: latch in_data; latch effective length L = min(in_len, MAX_LEN); clear hit_count and the two-bit history.
  - If L>0, go to SHIFT. If L==0, stay in IDLE and pulse done in the next cycle; no bits are sent.
- SHIFT:
  - In the cycle after the accept edge, x = bit L-1 with x_valid=1.
  - Each following cycle presents the next lower bit, for exactly L consecutive cycles with no bubbles.
  - After the cycle carrying bit 0: go to GAP if GAP>0; otherwise go to IDLE with done=1 on that IDLE cycle.
- GAP:
  - x=0, x_valid=0 for exactly GAP cycles, then IDLE with done=1 for one cycle.
  - in_ready stays 0 throughout GAP.
- Back-to-back frames: a word accepted on the done cycle starts SHIFT on the following cycle. The minimum frame period is therefore L+GAP+1 cycles.
- hit_count:
  - A two-bit history of the bits sent in the current frame is kept.
  - At the edge closing a SHIFT cycle, if history=="10" and x==1, hit_count increments.
  - Matches are overlapping: "10101" counts 2.
  - The count saturates at 2^CNT_W-1.
  - The history is cleared at each accept, so matches never span frames or gaps.
  - hit_count holds its value after the frame until the next accept or reset.
- in_valid while not in IDLE is ignored; in_data and in_len need only be stable on the accept edge.
- busy = (state != IDLE).

Test Plan:
- Frame: in_data=0x0005, in_len=3, GAP=2.
  - Required: x=1,0,1 with x_valid=1 on cycles 1-3 after accept.
  - Then x_valid=0 for 2 cycles, done pulse on cycle 6, hit_count=1, in_ready=0 on cycles 1-5.
- Overlap: in_data=0x0015, in_len=5.
  - Required: x=1,0,1,0,1 and final hit_count=2.
- Full width: in_data=0xFFFF, in_len=16.
  - Required: 16 consecutive x=1 with x_valid=1, hit_count=0, busy high for 18 cycles.
- Back-to-back: in_valid held high with frame 0x0005/len 3, then frame 0x0001/len 2.
  - Required: second frame's first bit appears the cycle after done.
  - Second frame sends 0,1 and hit_count=0 (history cleared).
- Reset mid-SHIFT: assert reset on the 2nd bit of a len-8 frame.
  - Required next cycle: x_valid=0, busy=0, hit_count=0, in_ready=1.
  - A new 0x0005/len 3 frame then behaves exactly as in the first scenario.
- Length edge cases:
  - in_len=0: done pulses the cycle after accept, and x_valid is never set.
  - in_len=20: exactly 16 bits are sent, starting with in_data bit 15.
